// File: rtl/jk_drive_sequencer.sv
// rtl/jk_drive_sequencer.sv - queued set/clear/toggle/hold driver for a JK element with a cycle-exact q model
module jk_drive_sequencer #(
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [DWELL_W-1:0]       cmd_dwell,
  output logic                     j,
  output logic                     k,
  input  logic                     q_fb,
  input  logic                     check_en,
  output logic                     q_model,
  output logic                     mismatch,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t               state;
  logic [1:0]           op_mem    [DEPTH];
  logic [DWELL_W-1:0]   dwell_mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DWELL_W-1:0]   dwl;
  logic                 have_cmd;
  logic                 push;
  logic                 pop;

  // Readiness looks only at the registered count, so a full FIFO refuses even when a pop coincides.
  assign cmd_ready = !reset && (fifo_count < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign have_cmd  = (fifo_count != '0);
  assign pop       = have_cmd && ((state == IDLE) || (dwl == '0));
  assign busy      = (state == DRIVE) || have_cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        op_mem[wr_ptr]    <= cmd_op;
        dwell_mem[wr_ptr] <= cmd_dwell;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      j        <= 1'b0;
      k        <= 1'b0;
      dwl      <= '0;
      q_model  <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      // q_model follows the same registered j/k the real element sees, so both change on the same edge.
      case ({j, k})
        2'b01:   q_model <= 1'b0;
        2'b10:   q_model <= 1'b1;
        2'b11:   q_model <= ~q_model;
        default: q_model <= q_model;
      endcase

      if (check_en && (q_fb != q_model)) begin
        mismatch <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            {j, k} <= op_mem[rd_ptr];
            dwl    <= dwell_mem[rd_ptr];
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          if (dwl != '0) begin
            dwl <= dwl - DWELL_W'(1);
          end else if (pop) begin
            {j, k} <= op_mem[rd_ptr];
            dwl    <= dwell_mem[rd_ptr];
          end else begin
            {j, k} <= 2'b00;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// tb/tb_jk_drive_sequencer.sv - scoreboard bench for jk_drive_sequencer
module tb_jk_drive_sequencer;

  localparam int DEPTH   = 4;
  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'b00;
  logic [DWELL_W-1:0] cmd_dwell = '0;
  logic               j;
  logic               k;
  logic               q_fb;
  logic               check_en = 1'b0;
  logic               q_model;
  logic               mismatch;
  logic               busy;
  logic [2:0]         fifo_count;

  logic q_el;
  logic fb_force = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic rst_q = 1'b0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [1:0] jk;
    int         avail;
  } slot_t;

  slot_t      sb[$];
  logic [1:0] jk_exp = 2'b00;
  logic [1:0] want_jk;
  logic       q_exp = 1'b0;

  always #5 clk = ~clk;

  jk_drive_sequencer #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_dwell(cmd_dwell),
    .j(j), .k(k), .q_fb(q_fb), .check_en(check_en),
    .q_model(q_model), .mismatch(mismatch), .busy(busy), .fifo_count(fifo_count)
  );

  // Stand-in for the real JK storage element.
  assign q_fb = fb_force ? 1'b0 : q_el;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
    if (reset) q_el <= 1'b0;
    else case ({j, k})
      2'b01:   q_el <= 1'b0;
      2'b10:   q_el <= 1'b1;
      2'b11:   q_el <= ~q_el;
      default: q_el <= q_el;
    endcase
  end

  // Each accepted command contributes dwell+1 pairs, usable from the second edge after acceptance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) begin
        sb.delete();
        q_exp   = 1'b0;
        want_jk = 2'b00;
      end else begin
        case (jk_exp)
          2'b01:   q_exp = 1'b0;
          2'b10:   q_exp = 1'b1;
          2'b11:   q_exp = ~q_exp;
          default: q_exp = q_exp;
        endcase
        want_jk = 2'b00;
        if (sb.size() > 0 && sb[0].avail <= cyc) begin
          want_jk = sb[0].jk;
          void'(sb.pop_front());
        end
      end
      jk_exp = want_jk;
      n_vec++;
      if ({j, k} !== want_jk) begin
        n_err++;
        $display("FAIL jk_drive cyc=%0d got=%b want=%b", cyc, {j, k}, want_jk);
      end
      n_vec++;
      if (q_model !== q_exp) begin
        n_err++;
        $display("FAIL q_model cyc=%0d got=%b want=%b", cyc, q_model, q_exp);
      end
    end
  end

  task automatic push(input logic [1:0] op, input int dw, output int waits);
    logic [DWELL_W-1:0] d;
    d = dw[DWELL_W-1:0];
    waits = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dwell = d;
    #1;
    while (!cmd_ready && waits < 100) begin
      @(negedge clk);
      #1;
      waits++;
    end
    n_vec++;
    if (!cmd_ready) begin
      n_err++;
      $display("FAIL push_timeout op=%b got_ready=%b want_ready=1", op, cmd_ready);
    end else begin
      for (int i = 0; i <= dw; i++) sb.push_back('{jk: op, avail: cyc + 2});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int jk11);
    int n;
    n = 0;
    jk11 = 0;
    do begin
      @(negedge clk);
      if (j && k) jk11++;
      n++;
    end while (busy && n < 200);
    n_vec++;
    if (busy) begin
      n_err++;
      $display("FAIL idle_timeout got_busy=%b want_busy=0", busy);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL ready_in_reset got=%b want=0", cmd_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    mon_en   = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({j, k, q_model, mismatch, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b want=00000", {j, k, q_model, mismatch, busy});
    end
    n_vec++;
    if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset got=%b want=1", cmd_ready); end
  endtask

  task automatic test_set_pulse();
    int w;
    push(2'b10, 0, w);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || fifo_count !== 3'd1) begin
      n_err++;
      $display("FAIL set_queued got busy=%b count=%0d want busy=1 count=1", busy, fifo_count);
    end
    @(negedge clk);
    n_vec++;
    if ({j, k, q_model} !== 3'b100) begin n_err++; $display("FAIL set_drive got=%b want=100", {j, k, q_model}); end
    @(negedge clk);
    n_vec++;
    if ({j, k, q_model, busy} !== 4'b0010) begin
      n_err++;
      $display("FAIL set_done got=%b want=0010", {j, k, q_model, busy});
    end
  endtask

  task automatic test_toggle();
    int w;
    int n11;
    push(2'b01, 0, w);
    push(2'b11, 3, w);
    wait_idle(n11);
    n_vec++;
    if (n11 != 4) begin n_err++; $display("FAIL toggle_len got=%0d want=4", n11); end
    n_vec++;
    if (q_model !== 1'b0) begin n_err++; $display("FAIL toggle_end got=%b want=0", q_model); end
  endtask

  task automatic test_full_queue();
    int w;
    int n11;
    push(2'b10, 15, w);
    push(2'b01, 1, w);
    push(2'b11, 1, w);
    push(2'b10, 1, w);
    push(2'b11, 1, w);
    n_vec++;
    if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_state got count=%0d ready=%b want count=4 ready=0", fifo_count, cmd_ready);
    end
    push(2'b01, 2, w);
    n_vec++;
    if (w != 13) begin n_err++; $display("FAIL full_wait got=%0d want=13", w); end
    wait_idle(n11);
    n_vec++;
    if (n11 != 4) begin n_err++; $display("FAIL full_toggles got=%0d want=4", n11); end
    n_vec++;
    if (mismatch !== 1'b0) begin n_err++; $display("FAIL clean_mismatch got=%b want=0", mismatch); end
  endtask

  task automatic test_mismatch();
    int w;
    int n;
    pulse_reset();
    fb_force = 1'b1;
    push(2'b10, 0, w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (q_model !== 1'b1 && n < 20);
    n_vec++;
    if (q_model !== 1'b1 || mismatch !== 1'b0) begin
      n_err++;
      $display("FAIL mis_before got q=%b mis=%b want q=1 mis=0", q_model, mismatch);
    end
    @(negedge clk);
    n_vec++;
    if (mismatch !== 1'b1) begin n_err++; $display("FAIL mis_set got=%b want=1", mismatch); end
    push(2'b01, 0, w);
    repeat (5) @(negedge clk);
    n_vec++;
    if (mismatch !== 1'b1) begin n_err++; $display("FAIL mis_sticky got=%b want=1", mismatch); end
    pulse_reset();
    fb_force = 1'b0;
    #1;
    n_vec++;
    if (mismatch !== 1'b0) begin n_err++; $display("FAIL mis_cleared got=%b want=0", mismatch); end
  endtask

  task automatic test_reset_mid_drive();
    int w;
    push(2'b10, 10, w);
    push(2'b11, 2, w);
    push(2'b01, 2, w);
    push(2'b11, 2, w);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL ready_mid_reset got=%b want=0", cmd_ready); end
    @(negedge clk);
    n_vec++;
    if ({j, k, q_model} !== 3'b000 || fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL mid_reset got jkq=%b count=%0d want jkq=000 count=0", {j, k, q_model}, fifo_count);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL post_reset_idle got busy=%b count=%0d want busy=0 count=0", busy, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_set_pulse();
    test_toggle();
    test_full_queue();
    test_mismatch();
    test_reset_mid_drive();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
